// File: rtl/sawtooth_pkg.sv
// -----------------------------------------------------------------------------
// sawtooth_pkg
//   Definitions shared by the sawtooth map engine and its scheduler:
//   - sched_state_e : scheduler FSM states
//   - FP_* constants: IEEE-754 single-precision values used by the map
//                     datapath and the scheduler's error response
// -----------------------------------------------------------------------------
package sawtooth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // arbitrate and accept one job
    ST_ISSUE = 2'd1,  // one-cycle start pulse to the engine
    ST_WAIT  = 2'd2,  // engine busy, wait for its done strobe
    ST_RESP  = 2'd3   // hold the response until it is accepted
  } sched_state_e;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] FP_HALF    = 32'h3F00_0000;

endpackage : sawtooth_pkg

// File: rtl/sawtooth_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: grants the first asserted request
//   at or after index ptr, wrapping modulo N.
//   Parameters: N  - number of requesters
//               IW - index width ($clog2(N))
//   Ports:      req       in  [N-1:0]  request vector
//               ptr       in  [IW-1:0] highest-priority index this round
//               grant     out [N-1:0]  one-hot grant, zero when no request
//               grant_idx out [IW-1:0] index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found             = 1'b1;
        grant[IW'(idx)]   = 1'b1;
        grant_idx         = IW'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/sawtooth_sched.sv
// -----------------------------------------------------------------------------
// sawtooth_sched
//   Shares one non-pipelined sawtooth map engine among NUM_REQ requesters.
//   One job in flight: arbitrate (round robin), start engine, wait for done,
//   return the result tagged with the requester index.
//
//   Optional build macro: SAWTOOTH_SCHED_TIMEOUT_EN
//     When defined, a WAIT that lasts TIMEOUT cycles without eng_done ends
//     with rsp_err=1 and rsp_data=quiet NaN. When undefined, WAIT lasts until
//     eng_done and rsp_err is tied 0.
//
//   Ports:
//     clk, reset_n              clock, async active-low reset
//     req_valid/req_ready       per-requester handshake (ready one-hot or 0)
//     req_x, req_eps            operands, requester i at slice i
//     eng_start                 one-cycle engine start pulse
//     eng_x, eng_eps            engine operands, stable from start to done
//     eng_done, eng_result      engine completion strobe and result
//     rsp_valid/rsp_ready       response handshake
//     rsp_id, rsp_data, rsp_err response payload
// -----------------------------------------------------------------------------
module sawtooth_sched
  import sawtooth_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PRECISION = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*PRECISION-1:0]   req_x,
  input  logic [NUM_REQ*PRECISION-1:0]   req_eps,
  output logic                           eng_start,
  output logic [PRECISION-1:0]           eng_x,
  output logic [PRECISION-1:0]           eng_eps,
  input  logic                           eng_done,
  input  logic [PRECISION-1:0]           eng_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [PRECISION-1:0]           rsp_data,
  output logic                           rsp_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      job_id;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic [PRECISION-1:0] sel_x, sel_eps;
  logic                 accept;
  logic                 to_expired;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is offered only in IDLE. Gating with reset_n keeps req_ready at its
  // reset value while reset is held, even if requesters keep req_valid high.
  assign req_ready = (reset_n && state_q == ST_IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign eng_start = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = job_id;

  // Operand select from the one-hot grant (AND-OR mux).
  always_comb begin
    sel_x   = '0;
    sel_eps = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x   = sel_x   | req_x[i*PRECISION +: PRECISION];
        sel_eps = sel_eps | req_eps[i*PRECISION +: PRECISION];
      end
    end
  end

`ifdef SAWTOOTH_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Counts completed WAIT cycles; expiry is seen on the TIMEOUT-th one.
  assign to_expired = (state_q == ST_WAIT) && (to_cnt == TO_W'(TIMEOUT - 1));
  assign rsp_err    = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        to_cnt <= '0;
      end else if (state_q == ST_WAIT && !eng_done) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      // A done strobe on the expiry cycle wins: the result is not an error.
      if (state_q == ST_WAIT && (eng_done || to_expired)) begin
        err_q <= !eng_done;
      end
    end
  end
`else
  assign to_expired = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)                   state_d = ST_ISSUE;
      ST_ISSUE:                               state_d = ST_WAIT;
      ST_WAIT:  if (eng_done || to_expired)   state_d = ST_RESP;
      ST_RESP:  if (rsp_ready)                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // State register and job/response datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state_q  <= ST_IDLE;
      rr_ptr   <= '0;
      job_id   <= '0;
      eng_x    <= '0;
      eng_eps  <= '0;
      rsp_data <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            eng_x   <= sel_x;
            eng_eps <= sel_eps;
            job_id  <= grant_idx;
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            rsp_data <= eng_result;
          end else if (to_expired) begin
            rsp_data <= PRECISION'(FP_QNAN);
          end
        end
        ST_RESP: begin
          // Pointer moves past the served requester so it cannot win again
          // while any other requester is waiting.
          if (rsp_ready) begin
            rr_ptr <= (job_id == ID_W'(NUM_REQ - 1)) ? '0 : job_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : sawtooth_sched

// File: tb/tb_sawtooth_sched.sv
// -----------------------------------------------------------------------------
// tb_sawtooth_sched
//   Directed bench for sawtooth_sched (NUM_REQ=4, PRECISION=32, TIMEOUT=64).
//   Inputs are driven just after the falling edge; outputs are checked 1 ns
//   later, well away from the rising edge the design uses.
// -----------------------------------------------------------------------------
module tb_sawtooth_sched;

  localparam int NUM_REQ = 4;
  localparam int P       = 32;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*P-1:0]   req_x;
  logic [NUM_REQ*P-1:0]   req_eps;
  logic                   eng_start;
  logic [P-1:0]           eng_x;
  logic [P-1:0]           eng_eps;
  logic                   eng_done;
  logic [P-1:0]           eng_result;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [P-1:0]           rsp_data;
  logic                   rsp_err;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  sawtooth_sched #(
    .NUM_REQ   (NUM_REQ),
    .PRECISION (P),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_eps    (req_eps),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_eps    (eng_eps),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] x_of(input int i);
    return 32'h4000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] eps_of(input int i);
    return 32'h3E00_0000 + 32'(i);
  endfunction

  task automatic load_default_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_x[i*P +: P]   = x_of(i);
      req_eps[i*P +: P] = eps_of(i);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'h0);
    check({pfx, "_eng_start"}, 32'(eng_start), 32'h0);
    check({pfx, "_eng_x"},     eng_x,          32'h0);
    check({pfx, "_eng_eps"},   eng_eps,        32'h0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({pfx, "_rsp_id"},    32'(rsp_id),    32'h0);
    check({pfx, "_rsp_data"},  rsp_data,       32'h0);
    check({pfx, "_rsp_err"},   32'(rsp_err),   32'h0);
  endtask

  // Waits for the start pulse (bounded), checks the granted operands, plays a
  // short engine latency and checks the tagged response. rsp_ready is high.
  task automatic do_job(input int exp_id, input logic [31:0] res);
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("rr_start_seen", 32'(eng_start), 32'h1);
    check("rr_grant_x",    eng_x,          x_of(exp_id));
    check("rr_grant_eps",  eng_eps,        eps_of(exp_id));
    repeat (5) @(negedge clk);
    eng_done   = 1'b1;
    eng_result = res;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rr_rsp_id",    32'(rsp_id),    32'(exp_id));
    check("rr_rsp_data",  rsp_data,       res);
  endtask

  initial begin
    int t0;
    int n;

    // ---------------- reset ----------------
    reset_n    = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_eps    = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    rsp_ready  = 1'b0;
    load_default_ops();
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;   // requests held during reset must not see ready
    #1;
    check_reset_vals("rst");
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- spurious done in IDLE ----------------
    @(negedge clk);
    eng_done   = 1'b1;
    eng_result = 32'hDEAD_BEEF;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("spur_rsp_valid0", 32'(rsp_valid), 32'h0);
    check("spur_eng_start0", 32'(eng_start), 32'h0);
    @(negedge clk); #1;
    check("spur_rsp_valid1", 32'(rsp_valid), 32'h0);

    // ---------------- single requester 1 ----------------
    req_x[1*P +: P]   = 32'h3F00_0000;
    req_eps[1*P +: P] = 32'h3F80_0000;
    req_valid         = 4'b0010;
    #1;
    check("single_req_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    // Done in the same cycle as start must be ignored.
    eng_done   = 1'b1;
    eng_result = 32'h1111_1111;
    #1;
    check("single_start",      32'(eng_start), 32'h1);
    check("single_eng_x",      eng_x,          32'h3F00_0000);
    check("single_eng_eps",    eng_eps,        32'h3F80_0000);
    check("single_ready_busy", 32'(req_ready), 32'h0);
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("single_start_pulse", 32'(eng_start), 32'h0);
    check("early_done_ignored", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    check("early_done_still_wait", 32'(rsp_valid), 32'h0);
    repeat (37) @(negedge clk);
    eng_done   = 1'b1;
    eng_result = 32'h3F00_0000;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id",    32'(rsp_id),    32'h1);
    check("single_rsp_data",  rsp_data,       32'h3F00_0000);
    check("single_rsp_err",   32'(rsp_err),   32'h0);

    // ---------------- back-pressure ----------------
    load_default_ops();
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_id",    32'(rsp_id),    32'h1);
      check("bp_rsp_data",  rsp_data,       32'h3F00_0000);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_eng_start", 32'(eng_start), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_released",   32'(rsp_valid), 32'h0);
    check("ptr_after_id1", 32'(req_ready), 32'h4);

    // ---------------- reset during WAIT ----------------
    @(negedge clk); #1;
    check("rst_job_start", 32'(eng_start), 32'h1);
    check("rst_job_x",     eng_x,          x_of(2));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_grant0", 32'(req_ready), 32'h1);

    // ---------------- round robin, all requesters valid ----------------
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_job(k % NUM_REQ, 32'h3E80_0000 + 32'(k));
    end
    req_valid = '0;
    @(negedge clk); #1;
    check("rr_drained", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b0;

    // ---------------- engine never completes ----------------
    req_valid = 4'b1000;
    #1;
    check("to_req_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("to_start", 32'(eng_start), 32'h1);
    t0 = cyc;
`ifdef SAWTOOTH_SCHED_TIMEOUT_EN
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("to_rsp_valid", 32'(rsp_valid), 32'h1);
    check("to_latency",   32'(cyc - t0),  32'd65);
    check("to_rsp_err",   32'(rsp_err),   32'h1);
    check("to_rsp_data",  rsp_data,       32'h7FC0_0000);
    check("to_rsp_id",    32'(rsp_id),    32'h3);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("to_released", 32'(rsp_valid), 32'h0);
`else
    n = 0;
    while (cyc - t0 < 1000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("nto_still_waiting", 32'(rsp_valid), 32'h0);
    check("nto_no_restart",    32'(eng_start), 32'h0);
    check("nto_rsp_err",       32'(rsp_err),   32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sawtooth_sched

// File: doc/sawtooth_sched.md
# sawtooth_sched

Round-robin scheduler that shares a single sawtooth chaotic-map engine among `NUM_REQ` requesters. Each requester posts an (x, epsilon) pair with a valid/ready handshake; the scheduler grants one job at a time, starts the engine, waits for its done strobe and returns the result tagged with the requester ID. It sits between the keystream generators of the image-encryption pipeline and the single non-pipelined FP sawtooth engine.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `PRECISION`, 32, operand/result width (IEEE-754 single)
- `TIMEOUT`, 64, engine-wait limit in cycles (used only with the timeout feature)
- `clk` in 1 — clock, all logic on rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `req_valid` in NUM_REQ — per-requester job valid
- `req_ready` out NUM_REQ — per-requester accept, one-hot or zero
- `req_x` in NUM_REQ*PRECISION — x operand, requester i at slice i
- `req_eps` in NUM_REQ*PRECISION — epsilon operand, same slicing
- `eng_start` out 1 — one-cycle start pulse to engine
- `eng_x`, `eng_eps` out PRECISION each — engine operands, held stable from start until done
- `eng_done` in 1 — engine completion strobe
- `eng_result` in PRECISION — engine result, valid with `eng_done`
- `rsp_valid` out 1 — response valid
- `rsp_ready` in 1 — response accept
- `rsp_id` out clog2(NUM_REQ) — requester index of response
- `rsp_data` out PRECISION — map result
- `rsp_err` out 1 — engine timed out (0 when feature compiled out)

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- IDLE: round-robin arbiter picks the first asserted `req_valid` at or after pointer `rr_ptr`; `req_ready` driven combinationally one-hot for that requester. On valid&ready: latch x, eps, id into registers; go ISSUE. No request: stay.
- ISSUE: `eng_start`=1 for exactly one cycle; go WAIT.
- WAIT: on `eng_done`, capture `eng_result` into `rsp_data`, `rsp_err`=0; go RESP. `eng_done` in any other state ignored.
- RESP: `rsp_valid`=1, `rsp_id`/`rsp_data`/`rsp_err` stable until `rsp_ready`. On handshake: `rr_ptr` <= (id+1) mod NUM_REQ; go IDLE.
- `req_ready` is zero in ISSUE, WAIT, RESP; one job in flight maximum.
- Requester i granted cannot be granted again while any other requester waits (starvation-free).
- Reset values: `req_ready`=0, `eng_start`=0, `eng_x`=`eng_eps`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `rr_ptr`=0.
- Reset mid-job: all state cleared immediately; job lost; engine is reset by the same `reset_n`.

## Timing
- Accept (valid&ready edge) to `eng_start` high: 1 cycle.
- `eng_done` to `rsp_valid`: 1 cycle.
- `rsp_ready` high on the first RESP cycle: next IDLE cycle can accept a new job; min job spacing = engine latency + 4 cycles.
- `eng_done` asserted in the same cycle as `eng_start`: not sampled (WAIT not yet entered).
- `rsp_valid` held indefinitely under back-pressure; engine idle meanwhile.

## Configuration
- `SAWTOOTH_SCHED_TIMEOUT_EN` defined: cycle counter runs in WAIT; if `TIMEOUT` cycles pass without `eng_done`, go RESP with `rsp_err`=1, `rsp_data`=32'h7FC00000 (quiet NaN). Counter cleared on entry to WAIT. `eng_done` on the same cycle as expiry wins (no error).
- Undefined: no counter, WAIT lasts until `eng_done`, `rsp_err` tied 0.

## Structure
- Shared package `sawtooth_pkg`: FSM state enum, `FP_QNAN`, `FP_ONE`, `FP_NEG_ONE`, `FP_HALF` constants reused by engine and scheduler.
- One sub-module: `rr_arbiter` (parameter N; inputs req, ptr; output one-hot grant, grant index).

## Test plan
- Single requester 1 posts x=0x3F000000, eps=0x3F800000; engine model returns 0x3F000000 after 40 cycles -> `eng_start` 1 cycle after accept, `rsp_id`=1, `rsp_data`=0x3F000000 one cycle after `eng_done`.
- All four `req_valid` held high continuously, `rsp_ready`=1 -> grant order 0,1,2,3,0,1; no ID repeated before the others served.
- `rsp_ready` held low 20 cycles after `rsp_valid` -> `rsp_*` stable, `req_ready` all zero, no second `eng_start`.
- With `SAWTOOTH_SCHED_TIMEOUT_EN`, `TIMEOUT`=64, engine never signals done -> `rsp_valid` 65 cycles after `eng_start`, `rsp_err`=1, `rsp_data`=0x7FC00000; without macro, still waiting at cycle 1000.
- `reset_n` pulled low during WAIT -> all outputs at reset values asynchronously; after release, requester 0 granted first.
- Spurious `eng_done` in IDLE -> ignored, no `rsp_valid`.
